// File: rtl/matrix_loader.sv
// Framed byte-stream parser: assembles N x N operand matrices and drives the multiplier trigger/busy handshake.
// Commit lands one cycle after the last payload byte (or after busy drops); no backpressure, bytes hitting a held commit are dropped with an error.
module matrix_loader #(
    parameter int N       = 3,
    parameter int W       = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_data,
    input  logic               i_valid,
    input  logic               i_mm_done,
    output logic [N*N*W-1:0]   o_mat_a,
    output logic [N*N*W-1:0]   o_mat_b,
    output logic               o_trigger,
    output logic               o_busy,
    output logic [1:0]         o_loaded,
    output logic               o_err,
    output logic [1:0]         o_err_code
);

    localparam int BPE    = (W + 7) / 8;
    localparam int NEL    = N * N;
    localparam int NBYTES = NEL * BPE;
    localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNTW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

    localparam logic [1:0] ERR_TIMEOUT = 2'b00;
    localparam logic [1:0] ERR_BUSY    = 2'b01;
    localparam logic [1:0] ERR_NOLOAD  = 2'b10;
    localparam logic [1:0] ERR_HDR     = 2'b11;

    localparam logic [1:0] OP_LOAD_A = 2'b00;
    localparam logic [1:0] OP_LOAD_B = 2'b01;
    localparam logic [1:0] OP_TRIG   = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LOAD   = 2'b01,
        S_COMMIT = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [7:0]          r_stage [NBYTES];
    logic [IDXW-1:0]     r_idx;
    logic [CNTW-1:0]     r_cnt;
    logic                r_tgt_b;
    logic                r_auto;
    logic [N*N*W-1:0]    r_mat_a;
    logic [N*N*W-1:0]    r_mat_b;
    logic [1:0]          r_loaded;
    logic                r_busy;
    logic                r_trigger;
    logic                r_err;
    logic [1:0]          r_err_code;

    logic [1:0]          w_hdr_op;
    logic                w_hdr_rsvd;
    logic                w_start_load;
    logic                w_byte_wr;
    logic                w_timeout;
    logic                w_commit;
    logic                w_clear;
    logic                w_trig;
    logic                w_err_vld;
    logic [1:0]          w_err_dat;
    logic [N*N*W-1:0]    w_stage_mat;

    assign w_hdr_op   = i_data[1:0];
    assign w_hdr_rsvd = |i_data[6:2];

    // Little-endian bytes per element; surplus top bits beyond W are simply never picked up.
    always_comb begin
        w_stage_mat = '0;
        for (int e = 0; e < NEL; e++) begin
            for (int b = 0; b < W; b++) begin
                w_stage_mat[e*W + b] = r_stage[e*BPE + b/8][b%8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_load) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end else if (w_byte_wr && (r_idx == LAST_IDX)) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (!r_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_start_load = 1'b0;
        w_byte_wr    = 1'b0;
        w_timeout    = 1'b0;
        w_commit     = 1'b0;
        w_clear      = 1'b0;
        w_trig       = 1'b0;
        w_err_vld    = 1'b0;
        w_err_dat    = ERR_TIMEOUT;
        unique case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    if (w_hdr_rsvd) begin
                        w_err_vld = 1'b1;
                        w_err_dat = ERR_HDR;
                    end else begin
                        unique case (w_hdr_op)
                            OP_LOAD_A, OP_LOAD_B: w_start_load = 1'b1;
                            OP_TRIG: begin
                                if (r_busy) begin
                                    w_err_vld = 1'b1;
                                    w_err_dat = ERR_BUSY;
                                end else if (r_loaded != 2'b11) begin
                                    w_err_vld = 1'b1;
                                    w_err_dat = ERR_NOLOAD;
                                end else begin
                                    w_trig = 1'b1;
                                end
                            end
                            OP_CLEAR: begin
                                if (r_busy) begin
                                    w_err_vld = 1'b1;
                                    w_err_dat = ERR_BUSY;
                                end else begin
                                    w_clear = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_LOAD: begin
                if (i_valid) begin
                    w_byte_wr = 1'b1;
                end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
                    w_timeout = 1'b1;
                    w_err_vld = 1'b1;
                    w_err_dat = ERR_TIMEOUT;
                end
            end
            S_COMMIT: begin
                // Operands must stay frozen under a running multiply, so the frame parks here.
                if (r_busy) begin
                    if (i_valid) begin
                        w_err_vld = 1'b1;
                        w_err_dat = ERR_BUSY;
                    end
                end else begin
                    w_commit = 1'b1;
                    w_trig   = r_tgt_b && r_auto && r_loaded[0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < NBYTES; i++) begin
                r_stage[i] <= '0;
            end
            r_idx      <= '0;
            r_cnt      <= '0;
            r_tgt_b    <= 1'b0;
            r_auto     <= 1'b0;
            r_mat_a    <= '0;
            r_mat_b    <= '0;
            r_loaded   <= 2'b00;
            r_busy     <= 1'b0;
            r_trigger  <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_trigger <= w_trig;
            r_err     <= w_err_vld;
            if (w_err_vld) begin
                r_err_code <= w_err_dat;
            end

            if (w_trig) begin
                r_busy <= 1'b1;
            end else if (r_busy && i_mm_done) begin
                r_busy <= 1'b0;
            end

            if (w_start_load) begin
                r_tgt_b <= i_data[0];
                r_auto  <= i_data[7];
                r_idx   <= '0;
                r_cnt   <= '0;
            end

            if (w_byte_wr) begin
                r_stage[r_idx] <= i_data;
                r_idx          <= r_idx + 1'b1;
                r_cnt          <= '0;
            end else if (r_state == S_LOAD) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_timeout) begin
                for (int i = 0; i < NBYTES; i++) begin
                    r_stage[i] <= '0;
                end
            end

            if (w_clear) begin
                r_mat_a  <= '0;
                r_mat_b  <= '0;
                r_loaded <= 2'b00;
            end

            if (w_commit) begin
                if (r_tgt_b) begin
                    r_mat_b     <= w_stage_mat;
                    r_loaded[1] <= 1'b1;
                end else begin
                    r_mat_a     <= w_stage_mat;
                    r_loaded[0] <= 1'b1;
                end
            end
        end
    end

    assign o_mat_a    = r_mat_a;
    assign o_mat_b    = r_mat_b;
    assign o_trigger  = r_trigger;
    assign o_busy     = r_busy;
    assign o_loaded   = r_loaded;
    assign o_err      = r_err;
    assign o_err_code = r_err_code;

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboarded random bench for matrix_loader (3x3x8, short timeout) plus a directed 2x2x12 instance.
module tb_matrix_loader;

    localparam int N1  = 3;
    localparam int W1  = 8;
    localparam int T1  = 20;
    localparam int BPE1 = (W1 + 7) / 8;
    localparam int NB1 = N1 * N1 * BPE1;
    localparam int MW1 = N1 * N1 * W1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance 1
    logic           rst1, v1, done1;
    logic [7:0]     d1;
    logic [MW1-1:0] mat_a1, mat_b1;
    logic           trig1, busy1, err1;
    logic [1:0]     ld1, code1;

    // instance 2 (N=2, W=12)
    logic           rst2, v2, done2;
    logic [7:0]     d2;
    logic [47:0]    mat_a2, mat_b2;
    logic           trig2, busy2, err2;
    logic [1:0]     ld2, code2;

    matrix_loader #(.N(N1), .W(W1), .TIMEOUT(T1)) dut1 (
        .i_clk(clk), .i_rst(rst1), .i_data(d1), .i_valid(v1), .i_mm_done(done1),
        .o_mat_a(mat_a1), .o_mat_b(mat_b1), .o_trigger(trig1), .o_busy(busy1),
        .o_loaded(ld1), .o_err(err1), .o_err_code(code1));

    matrix_loader #(.N(2), .W(12), .TIMEOUT(T1)) dut2 (
        .i_clk(clk), .i_rst(rst2), .i_data(d2), .i_valid(v2), .i_mm_done(done2),
        .o_mat_a(mat_a2), .o_mat_b(mat_b2), .o_trigger(trig2), .o_busy(busy2),
        .o_loaded(ld2), .o_err(err2), .o_err_code(code2));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [MW1-1:0] a;
        logic [MW1-1:0] b;
        logic [1:0]     ld;
    } snap_t;

    snap_t      q_state[$];
    snap_t      q_trig[$];
    logic [1:0] q_err[$];

    // Reference model: architectural view only (matrices, loaded bits, busy, parked frame).
    logic [MW1-1:0] m_a, m_b, pend_vec;
    logic [1:0]     m_ld;
    bit             m_busy, pend, pend_b, pend_auto;
    logic [7:0]     fb[NB1];

    function automatic logic [MW1-1:0] frame_vec();
        logic [MW1-1:0] vec;
        logic [31:0]    elem;
        vec = '0;
        for (int e = 0; e < N1 * N1; e++) begin
            elem = 0;
            for (int k = 0; k < BPE1; k++) elem = elem | (32'(fb[e*BPE1 + k]) << (8 * k));
            vec[e*W1 +: W1] = elem[W1-1:0];
        end
        return vec;
    endfunction

    task automatic apply_commit(input bit tgt_b, input bit au, input logic [MW1-1:0] vec);
        snap_t old;
        old = {m_a, m_b, m_ld};
        if (tgt_b) begin m_b = vec; m_ld[1] = 1'b1; end
        else       begin m_a = vec; m_ld[0] = 1'b1; end
        if ({m_a, m_b, m_ld} != old) q_state.push_back({m_a, m_b, m_ld});
        if (tgt_b && au && m_ld[0]) begin
            q_trig.push_back({m_a, m_b, m_ld});
            m_busy = 1'b1;
        end
    endtask

    task automatic cyc(input bit v, input logic [7:0] d, input bit dn);
        @(posedge clk); #1;
        v1 = v; d1 = d; done1 = dn;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] hdr, input bit gaps);
        cyc(1'b1, hdr, 1'b0);
        for (int i = 0; i < NB1; i++) begin
            if (gaps) idle($urandom_range(0, 3));
            cyc(1'b1, fb[i], 1'b0);
        end
        if (m_busy) begin
            pend = 1'b1; pend_b = hdr[0]; pend_auto = hdr[7]; pend_vec = frame_vec();
        end else begin
            apply_commit(hdr[0], hdr[7], frame_vec());
        end
        idle(2);
    endtask

    task automatic cmd_trig(input logic [7:0] hdr);
        cyc(1'b1, hdr, 1'b0);
        if (pend || m_busy)     q_err.push_back(2'b01);
        else if (m_ld != 2'b11) q_err.push_back(2'b10);
        else begin
            q_trig.push_back({m_a, m_b, m_ld});
            m_busy = 1'b1;
        end
        idle(2);
    endtask

    task automatic cmd_clear();
        cyc(1'b1, {1'($urandom_range(0, 1)), 7'h03}, 1'b0);
        if (pend || m_busy) q_err.push_back(2'b01);
        else begin
            if ({m_a, m_b, m_ld} != '0) q_state.push_back('0);
            m_a = '0; m_b = '0; m_ld = 2'b00;
        end
        idle(2);
    endtask

    task automatic cmd_bad(input logic [7:0] hdr);
        cyc(1'b1, hdr, 1'b0);
        q_err.push_back(pend ? 2'b01 : 2'b11);
        idle(2);
    endtask

    task automatic cmd_timeout(input int k);
        cyc(1'b1, {1'($urandom_range(0, 1)), 6'b0, 1'($urandom_range(0, 1))}, 1'b0);
        for (int i = 0; i < k; i++) cyc(1'b1, 8'($urandom), 1'b0);
        q_err.push_back(2'b00);
        idle(T1 + 5);
    endtask

    task automatic mm_pulse();
        bit was_busy;
        was_busy = m_busy;
        chk("busy_before_done", busy1, m_busy);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        if (was_busy) begin
            chk("busy_clears_after_done", busy1, 1'b0);
            m_busy = 1'b0;
            if (pend) begin
                pend = 1'b0;
                apply_commit(pend_b, pend_auto, pend_vec);
            end
        end
        idle(2);
    endtask

    // Monitor: pops expectations whenever the DUT shows an error, trigger or operand change.
    bit         mon_on = 1'b0;
    snap_t      mon_prev, mon_cur, mon_exp;
    logic       mon_prev_busy;
    logic [1:0] mon_code;

    always @(negedge clk) begin
        if (mon_on) begin
            if (err1) begin
                if (q_err.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL err_unexpected: got code %0d, expected no error", code1);
                end else begin
                    mon_code = q_err.pop_front();
                    chk("err_code", code1, mon_code);
                end
            end
            if (trig1) begin
                if (q_trig.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL trig_unexpected: got trigger, expected none");
                end else begin
                    mon_exp = q_trig.pop_front();
                    chk("trig_busy", busy1, 1'b1);
                    chk("trig_mat_a", mat_a1, mon_exp.a);
                    chk("trig_mat_b", mat_b1, mon_exp.b);
                end
            end
            mon_cur = {mat_a1, mat_b1, ld1};
            if (mon_cur != mon_prev) begin
                chk("operands_stable_while_busy", mon_prev_busy, 1'b0);
                if (q_state.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL state_unexpected: got loaded %0d, expected no change", ld1);
                end else begin
                    mon_exp = q_state.pop_front();
                    chk("mat_a", mat_a1, mon_exp.a);
                    chk("mat_b", mat_b1, mon_exp.b);
                    chk("loaded", ld1, mon_exp.ld);
                end
            end
            mon_prev      = mon_cur;
            mon_prev_busy = busy1;
        end
    end

    task automatic cyc2(input bit v, input logic [7:0] d);
        @(posedge clk); #1;
        v2 = v; d2 = d;
    endtask

    initial begin
        logic [7:0] w12_a [8];
        logic [7:0] w12_b [8];
        int op;
        w12_a = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'h0D};
        w12_b = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
        rst1 = 1'b0; v1 = 1'b0; d1 = 8'h00; done1 = 1'b0;
        rst2 = 1'b0; v2 = 1'b0; d2 = 8'h00; done2 = 1'b0;
        m_a = '0; m_b = '0; m_ld = 2'b00; m_busy = 1'b0; pend = 1'b0;
        pend_b = 1'b0; pend_auto = 1'b0; pend_vec = '0;
        repeat (3) @(posedge clk);
        #1 rst1 = 1'b1; rst2 = 1'b1;
        @(negedge clk);
        chk("rst_mat_a", mat_a1, '0);
        chk("rst_mat_b", mat_b1, '0);
        chk("rst_loaded", ld1, 2'b00);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_trigger", trig1, 1'b0);
        chk("rst_err", err1, 1'b0);
        chk("rst_err_code", code1, 2'b00);
        mon_prev = {mat_a1, mat_b1, ld1};
        mon_prev_busy = busy1;
        mon_on = 1'b1;

        // Directed walk through the main scenarios
        cmd_trig(8'h02);
        for (int i = 0; i < NB1; i++) fb[i] = 8'(i + 1);
        send_frame(8'h00, 1'b0);
        for (int i = 0; i < NB1; i++) fb[i] = 8'(NB1 - i);
        send_frame(8'h81, 1'b0);
        for (int i = 0; i < NB1; i++) fb[i] = 8'(8'h10 + i);
        send_frame(8'h01, 1'b1);
        cmd_trig(8'h02);
        mm_pulse();
        cmd_timeout(4);
        for (int i = 0; i < NB1; i++) fb[i] = 8'($urandom);
        send_frame(8'h00, 1'b1);
        cmd_bad(8'h14);
        mm_pulse();

        repeat (120) begin
            op = $urandom_range(0, 6);
            if (pend && (op == 0 || op == 1 || op == 6)) op = 4;
            case (op)
                0, 1: begin
                    for (int i = 0; i < NB1; i++) fb[i] = 8'($urandom);
                    send_frame({1'($urandom_range(0, 1)), 6'b0, 1'(op)}, 1'b1);
                end
                2: cmd_trig({1'($urandom_range(0, 1)), 7'h02});
                3: cmd_clear();
                4: mm_pulse();
                5: cmd_bad({1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)), 2'($urandom_range(0, 3))});
                default: cmd_timeout($urandom_range(1, NB1 - 1));
            endcase
        end
        repeat (3) if (m_busy) mm_pulse();
        idle(5);
        chk("q_state_drained", q_state.size(), 0);
        chk("q_trig_drained", q_trig.size(), 0);
        chk("q_err_drained", q_err.size(), 0);

        // 2x2 with 12-bit elements: little-endian assembly, top bits dropped
        cyc2(1'b1, 8'h00);
        for (int i = 0; i < 8; i++) cyc2(1'b1, w12_a[i]);
        repeat (3) cyc2(1'b0, 8'h00);
        chk("w12_mat_a", mat_a2, {12'hDF0, 12'hABC, 12'h678, 12'h234});
        chk("w12_loaded", ld2, 2'b01);
        chk("w12_no_trigger", trig2, 1'b0);
        cyc2(1'b1, 8'h01);
        for (int i = 0; i < 3; i++) cyc2(1'b1, w12_b[i]);
        rst2 = 1'b0;
        #1;
        chk("w12_rst_mat_a", mat_a2, '0);
        chk("w12_rst_mat_b", mat_b2, '0);
        chk("w12_rst_flags", {trig2, busy2, ld2, err2, code2}, '0);
        cyc2(1'b0, 8'h00);
        rst2 = 1'b1;
        cyc2(1'b1, 8'h00);
        for (int i = 0; i < 8; i++) cyc2(1'b1, w12_b[i]);
        repeat (3) cyc2(1'b0, 8'h00);
        chk("w12_reload_mat_a", mat_a2, {12'h004, 12'h003, 12'h002, 12'h001});
        chk("w12_reload_mat_b", mat_b2, '0);
        chk("w12_reload_loaded", ld2, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
- Byte-stream front end for the matrix multiplier, generalised to N×N matrices with W-bit elements.
- Parses framed commands from the UART receiver: load A, load B, trigger multiply, clear.
- Assembles elements into flattened A/B operand buses and drives the multiplier trigger/busy handshake.
- Holds operands stable while a multiply is in flight and reports framing, timeout and conflict errors.

Parameters:
- N, 3, matrix dimension (N×N elements)
- W, 8, element width in bits; BPE = ceil(W/8) bytes per element
- TIMEOUT, 100000, max i_clk cycles between payload bytes; 0 disables the timeout

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-low reset
- i_data  in  8  received byte
- i_valid  in  1  one-cycle strobe, i_data valid
- i_mm_done  in  1  multiplier result ready; sampled only while o_busy
- o_mat_a  out  N*N*W  operand A, row-major; element (r,c) at [(r*N+c)*W +: W]
- o_mat_b  out  N*N*W  operand B, same layout
- o_trigger  out  1  one-cycle multiply start pulse
- o_busy  out  1  multiply in flight
- o_loaded  out  2  bit0 = A valid, bit1 = B valid
- o_err  out  1  one-cycle error pulse
- o_err_code  out  2  00 timeout, 01 busy conflict, 10 operands not loaded, 11 bad header; holds last code

Behaviour:
- Reset (async, i_rst=0):
  - All outputs 0, staging cleared, state IDLE, byte index 0, timeout counter 0.
  - Reset mid-frame discards the partial frame.
- Frame format: one header byte, then N*N*BPE payload bytes.
  - Elements arrive row-major.
  - Bytes within an element are little-endian; surplus high bits of the top byte are dropped when W is not a multiple of 8.
- Header decode:
  - [1:0] op: 00 load A, 01 load B, 10 trigger, 11 clear.
  - [7] auto: trigger after a B load.
  - [6:2] must be 0; otherwise err 11, stay IDLE.
- IDLE, header accepted on i_valid:
  - op 00/01: latch target and auto; go LOAD, index=0, counter=0.
  - op 10, busy: err 01, ignored.
  - op 10, o_loaded≠11: err 10, ignored.
  - op 10, otherwise: o_trigger=1 on the next cycle; o_busy=1 from that same cycle.
  - op 11, busy: err 01, ignored.
  - op 11, otherwise: o_mat_a, o_mat_b and o_loaded cleared on the next cycle.
- LOAD:
  - Each i_valid writes i_data to staging byte[index], index++, counter cleared.
  - Counter increments on cycles without i_valid.
  - Counter reaching TIMEOUT: err 00, staging discarded, go IDLE.
  - Byte written at index = N*N*BPE-1: go COMMIT.
- COMMIT:
  - Busy: wait, staging held; i_valid bytes received here are dropped with err 01.
  - Not busy, single cycle: copy staging into the target matrix, set its o_loaded bit, go IDLE.
  - If target=B, auto=1 and A already loaded: o_trigger pulses in the cycle after the commit edge, together with the updated o_mat_b and o_busy rising.
- Operand stability: o_mat_a/o_mat_b never change while o_busy=1.
- Multiply completion:
  - o_busy clears the cycle after i_mm_done is sampled high.
  - i_mm_done while not busy is ignored.
  - Header op 10 in the same cycle as i_mm_done sees busy=1: err 01.
- o_err:
  - Single-cycle pulse per event.
  - o_err_code updates in the same cycle as the o_err pulse.
  - Simultaneous events cannot occur: at most one byte per cycle.
- Re-loading A while B is loaded is legal: the A bit is refreshed; B is untouched.

Test Plan:
- Reset, header 0x00, bytes 1..9 (N=3, W=8) → o_mat_a row-major 1..9, o_loaded=01, no o_trigger, no o_err.
- Then header 0x81, bytes 9..1 → o_mat_b loaded, o_loaded=11, o_trigger single pulse the cycle after commit, o_busy=1; i_mm_done pulse → o_busy=0 next cycle.
- While busy, send 0x01 plus 9 bytes → frame waits in COMMIT, o_mat_b unchanged until i_mm_done, then commits; header 0x02 sent while busy → o_err, code 01.
- After reset, header 0x02 → o_err code 10, o_trigger stays 0.
- TIMEOUT=20: header 0x00, 4 bytes, then 25 idle cycles → o_err code 00, o_loaded unchanged; a subsequent full frame loads correctly. Header 0x14 → o_err code 11.
- W=12, N=2: header 0x00, bytes 34 12 78 56 BC 9A F0 0D → elements 0x234, 0x678, 0xABC, 0xDF0; assert i_rst mid-frame → all outputs 0.
